// File: rtl/grant_hold_mux_if.sv
// grant_hold_mux_if
//   Bundles the requester side, arbiter side and output channel of the
//   burst-hold mux into one interface.
//   slave  : view taken by grant_hold_mux itself.
//   master : view taken by whatever drives the requesters/arbiter/sink.
//   Signals:
//     req, last, in_data   per-requester valid, end-of-burst, data (lane i at [i*DW +: DW])
//     in_ready             per-requester ready back to the requesters
//     arb_req, arb_gnt     masked request vector out, one-hot grant back in
//     grant                registered one-hot ownership
//     out_valid/out_data/out_last/out_ready   single output channel
//     timeout              one-cycle pulse after a forced release
interface grant_hold_mux_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    logic [N-1:0]    req;
    logic [N-1:0]    last;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic [N-1:0]    arb_req;
    logic [N-1:0]    arb_gnt;
    logic [N-1:0]    grant;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            out_ready;
    logic            timeout;

    modport slave (
        input  req, last, in_data, arb_gnt, out_ready,
        output in_ready, arb_req, grant, out_valid, out_data, out_last, timeout
    );

    modport master (
        output req, last, in_data, arb_gnt, out_ready,
        input  in_ready, arb_req, grant, out_valid, out_data, out_last, timeout
    );
endinterface

// File: rtl/grant_hold_mux.sv
// grant_hold_mux
//   Burst-hold stage behind a combinational fixed-priority arbiter. In IDLE
//   it forwards the raw request vector to the arbiter and captures the
//   returned grant; in OWN it masks the arbiter and steers the owner's beats
//   onto one valid/ready channel until the owner sends last, hits the
//   MAX_HOLD beat limit, or drops its request.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    grant_hold_mux_if.slave (requesters, arbiter, output channel)
module grant_hold_mux #(
    parameter int N        = 4,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    grant_hold_mux_if.slave   bus
);
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam int IW = $clog2(N);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] OWN  = 1'b1;

    localparam logic [CW-1:0] CNT_FORCE = CW'(MAX_HOLD - 1);

    logic [0:0]    state;
    logic [N-1:0]  grant_q;
    logic [CW-1:0] beat_cnt;
    logic          timeout_q;

    logic [N-1:0]  cand;
    logic [N-1:0]  cand_low;
    logic [IW-1:0] owner;
    logic          own;
    logic          owner_req;
    logic          owner_last;
    logic          force_rel;
    logic          xfer;

    // The arbiter may hand back a grant on a non-requesting line or several
    // bits at once; AND with req and keep only the lowest bit so ownership
    // stays one-hot.
    assign cand     = bus.arb_gnt & bus.req;
    assign cand_low = cand & (-cand);

    // Encode the one-hot ownership register into a lane index.
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        owner = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) owner = IW'(i);
        end
    end

    assign own        = (state == OWN);
    assign owner_req  = own & bus.req[owner];
    assign owner_last = bus.last[owner];
    assign force_rel  = (beat_cnt == CNT_FORCE);
    assign xfer       = owner_req & bus.out_ready;

    // Zero-latency mux: everything below is combinational from grant_q.
    assign bus.arb_req   = own ? '0 : bus.req;
    assign bus.grant     = grant_q;
    assign bus.out_valid = owner_req;
    assign bus.out_data  = own ? bus.in_data[owner*DW +: DW] : '0;
    assign bus.out_last  = own & (owner_last | force_rel);
    assign bus.in_ready  = (own & bus.out_ready) ? grant_q : '0;
    assign bus.timeout   = timeout_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_q   <= '0;
            beat_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (state == IDLE) begin
                if (|cand) begin
                    grant_q  <= cand_low;
                    beat_cnt <= '0;
                    state    <= OWN;
                end
            end else begin
                // Release on abandon, on a last beat, or on the beat limit.
                if (!owner_req || (xfer && (owner_last || force_rel))) begin
                    state     <= IDLE;
                    grant_q   <= '0;
                    beat_cnt  <= '0;
                    // Timeout only flags a limit hit that was not also a real last.
                    timeout_q <= xfer & force_rel & ~owner_last;
                end else if (xfer) begin
                    beat_cnt <= beat_cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_grant_hold_mux.sv
// tb_grant_hold_mux
//   Self-checking bench for grant_hold_mux (N=4, DW=8, MAX_HOLD=4). A
//   behavioural model tracks "who owns the channel and how many beats it has
//   sent"; it checks the control outputs each cycle and pushes every beat it
//   expects onto a scoreboard queue, which a separate monitor drains whenever
//   the DUT completes a transfer.
module tb_grant_hold_mux;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MH = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic clk;
    logic rst_n;
    logic noise_mode;
    logic [N-1:0] noise;

    int checks;
    int failures;
    int to_seen;

    beat_t sb[$];

    // Model state: owner index (-1 when nobody holds), beats sent so far,
    // expected timeout level in the current cycle, and whether a beat moved.
    int m_owner;
    int m_cnt;
    bit m_to;
    bit m_xfer;

    grant_hold_mux_if #(.N(N), .DW(DW)) bus ();

    grant_hold_mux #(.N(N), .DW(DW), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Fixed-priority arbiter (bit 0 wins), optionally replaced by junk grants.
    assign bus.arb_gnt = noise_mode ? noise : (bus.arb_req & (-bus.arb_req));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lane(input int i, input logic [7:0] v);
        logic [31:0] w;
        w = 32'(v) << (i * DW);
        return w;
    endfunction

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l,
                         input logic [31:0] d, input logic ordy);
        bus.req       = r;
        bus.last      = l;
        bus.in_data   = d;
        bus.out_ready = ordy;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_to    = 0;
        m_xfer  = 0;
        sb.delete();
    endtask

    // One clock cycle: check at the falling edge, advance the model at the
    // rising edge, return 1 time unit after it (where inputs are driven).
    task automatic step();
        logic [N-1:0] eg, eir, ear;
        logic ev, el, frc;
        int n_owner, n_cnt, w;
        bit n_to;
        beat_t b;
        @(negedge clk);
        eg = '0; eir = '0; ear = '0; ev = 0; el = 0; frc = 0;
        if (m_owner < 0) begin
            ear = bus.req;
        end else begin
            eg  = 4'b0001 << m_owner;
            ev  = bus.req[m_owner];
            frc = (m_cnt == MH - 1);
            el  = bus.last[m_owner] | frc;
            eir = bus.out_ready ? eg : '0;
        end
        if (bus.timeout) to_seen++;
        check("grant",     32'(bus.grant),     32'(eg));
        check("arb_req",   32'(bus.arb_req),   32'(ear));
        check("out_valid", 32'(bus.out_valid), 32'(ev));
        check("in_ready",  32'(bus.in_ready),  32'(eir));
        check("timeout",   32'(bus.timeout),   32'(m_to));
        if (ev) check("out_last", 32'(bus.out_last), 32'(el));
        m_xfer = ev && bus.out_ready;
        if (m_xfer) begin
            b.data = bus.in_data[m_owner*DW +: DW];
            b.last = el;
            sb.push_back(b);
        end
        n_owner = m_owner; n_cnt = m_cnt; n_to = 0;
        if (m_owner < 0) begin
            // Whoever the arbiter named, provided it is actually requesting.
            w = lowest((noise_mode ? noise : (4'b0001 << lowest(bus.req))) & bus.req);
            if (bus.req == '0) w = -1;
            if (w >= 0) begin n_owner = w; n_cnt = 0; end
        end else if (!ev) begin
            n_owner = -1; n_cnt = 0;
        end else if (m_xfer) begin
            if (el) begin
                n_owner = -1; n_cnt = 0;
                n_to = frc && !bus.last[m_owner];
            end else begin
                n_cnt = m_cnt + 1;
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            m_owner = -1; m_cnt = 0; m_to = 0;
        end else begin
            m_owner = n_owner; m_cnt = n_cnt; m_to = n_to;
        end
        #1;
    endtask

    // Scoreboard monitor: pops one expected beat per DUT transfer.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_depth_on_beat", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", 32'(bus.out_data), 32'(e.data));
                    check("beat_last", 32'(bus.out_last), 32'(e.last));
                end
            end
        end
    end

    initial begin
        int b, t0;
        logic [N-1:0] r, l;
        logic [31:0] d;
        logic [4:0] rdy_pat;
        checks = 0; failures = 0; to_seen = 0;
        noise_mode = 0; noise = '0;
        model_reset();
        drive('0, '0, '0, 1'b1);
        rst_n = 1'b0;
        #12;
        check("reset_grant",     32'(bus.grant),     32'd0);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_timeout",   32'(bus.timeout),   32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single burst from requester 2.
        drive('0, '0, '0, 1'b1); step();
        drive(4'b0100, '0, lane(2, 8'hA1), 1'b1); step();
        check("single_grant", 32'(bus.grant), 32'h4);
        drive(4'b0100, '0, lane(2, 8'hA1), 1'b1); step();
        drive(4'b0100, '0, lane(2, 8'hA2), 1'b1); step();
        drive(4'b0100, 4'b0100, lane(2, 8'hA3), 1'b1); step();
        drive('0, '0, '0, 1'b1); step();

        // Requester 3 holds through a 4-beat burst while requester 0 waits.
        drive(4'b1000, '0, lane(3, 8'hB0), 1'b1); step();
        for (int k = 0; k < 4; k++) begin
            r = 4'b1000 | ((k >= 1) ? 4'b0001 : 4'b0000);
            l = (k == 3) ? 4'b1000 : 4'b0000;
            drive(r, l, lane(3, 8'hB0 + 8'(k)) | lane(0, 8'hC0), 1'b1); step();
        end
        drive(4'b0001, '0, lane(0, 8'hC0), 1'b1); step();
        check("prio_regrant", 32'(bus.grant), 32'h1);
        drive(4'b0001, 4'b0001, lane(0, 8'hC0), 1'b1); step();
        drive('0, '0, '0, 1'b1); step();

        // Requester 1 streams 6 beats without last: forced release after 4.
        t0 = to_seen; b = 0;
        drive(4'b0010, '0, lane(1, 8'hD0), 1'b1); step();
        for (int k = 0; k < 20 && b < 6; k++) begin
            drive(4'b0010, '0, lane(1, 8'hD0 + 8'(b)), 1'b1); step();
            if (m_xfer) b++;
        end
        check("force_beats", 32'(b), 32'd6);
        drive('0, '0, '0, 1'b1); step();
        drive('0, '0, '0, 1'b1); step();
        check("force_timeout_pulses", 32'(to_seen - t0), 32'd1);

        // Backpressure on requester 0.
        rdy_pat = 5'b11001;
        b = 0;
        drive(4'b0001, '0, lane(0, 8'hE0), 1'b1); step();
        for (int p = 0; p < 5; p++) begin
            drive(4'b0001, (b == 2) ? 4'b0001 : 4'b0000, lane(0, 8'hE0 + 8'(b)), rdy_pat[p]); step();
            if (m_xfer) b++;
        end
        check("bp_transfers", 32'(b), 32'd3);
        drive('0, '0, '0, 1'b1); step();

        // Owner 2 abandons after one beat; requester 3 waits behind it.
        d = lane(2, 8'hF0) | lane(3, 8'hF8);
        drive(4'b1100, '0, d, 1'b1); step();
        drive(4'b1100, '0, d, 1'b1); step();
        drive(4'b1000, '0, d, 1'b1); step();
        drive(4'b1000, '0, d, 1'b1); step();
        drive(4'b1000, 4'b1000, d, 1'b1); step();
        drive('0, '0, '0, 1'b1); step();

        // Asynchronous reset in the middle of a burst.
        drive(4'b0010, '0, lane(1, 8'h55), 1'b1); step();
        drive(4'b0010, '0, lane(1, 8'h56), 1'b1); step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_grant",     32'(bus.grant),     32'd0);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_in_ready",  32'(bus.in_ready),  32'd0);
        check("arst_timeout",   32'(bus.timeout),   32'd0);
        model_reset();
        step();
        #2 rst_n = 1'b1;
        step();
        drive(4'b0010, 4'b0010, lane(1, 8'h57), 1'b1); step();
        drive('0, '0, '0, 1'b1); step();

        // Randomized traffic, including arbiters that return junk grants.
        r = '0;
        for (int i = 0; i < 800; i++) begin
            for (int j = 0; j < N; j++) if ($urandom_range(0, 7) == 0) r[j] = ~r[j];
            for (int j = 0; j < N; j++) l[j] = ($urandom_range(0, 3) == 0);
            noise_mode = ($urandom_range(0, 4) == 0);
            noise      = N'($urandom);
            drive(r, l, $urandom, ($urandom_range(0, 3) != 0));
            step();
        end
        noise_mode = 0;
        drive('0, '0, '0, 1'b1);
        step();
        step();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
